// File: rtl/frame_reader.sv
// frame_reader - display side of the frame buffer.
//
// Generates VGA raster timing (640x480 by default). For every active pixel it
// issues a row-major RAM read address. It delays the timing flags by the RAM
// read latency so that the returned pixel data comes out aligned with
// sync and blank.
//
// Optional build macro: FRAME_READER_TEST_PATTERN_EN
//   Adds input i_pattern_sel. When it is high, active pixels show 8 vertical
//   colour bars instead of RAM data, and no RAM reads are issued.
//
// Ports
//   i_clk          pixel clock
//   i_reset_n      synchronous reset, active-low
//   i_rd_data      RAM read data, [2]=R [1]=G [0]=B
//   i_pattern_sel  colour-bar select (only with FRAME_READER_TEST_PATTERN_EN)
//   o_rd_enable    RAM read strobe
//   o_rd_address   RAM read address
//   o_data         pixel to the DAC, zero while blanked
//   o_hsync        horizontal sync, active-low
//   o_vsync        vertical sync, active-low
//   o_blank_n      1 = active video
//   o_frame_start  one-cycle pulse on the first active pixel of a frame
module frame_reader #(
  parameter int COLOR_CHANNEL = 8,
  parameter int WIDTH_IMAGE   = 640,
  parameter int HEIGHT_IMAGE  = 480,
  parameter int MAX_ADDRESS   = 307199,
  parameter int RAM_LATENCY   = 2,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [2:0][COLOR_CHANNEL-1:0] i_rd_data,
`ifdef FRAME_READER_TEST_PATTERN_EN
  input  logic                          i_pattern_sel,
`endif
  output logic                          o_rd_enable,
  output logic [18:0]                   o_rd_address,
  output logic [2:0][COLOR_CHANNEL-1:0] o_data,
  output logic                          o_hsync,
  output logic                          o_vsync,
  output logic                          o_blank_n,
  output logic                          o_frame_start
);

  localparam int H_TOTAL = WIDTH_IMAGE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT_IMAGE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_ACT        = 10'(WIDTH_IMAGE);
  localparam logic [9:0]  H_SYNC_START = 10'(WIDTH_IMAGE + H_FRONT);
  localparam logic [9:0]  H_SYNC_END   = 10'(WIDTH_IMAGE + H_FRONT + H_SYNC);
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT        = 10'(HEIGHT_IMAGE);
  localparam logic [9:0]  V_SYNC_START = 10'(HEIGHT_IMAGE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END   = 10'(HEIGHT_IMAGE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [18:0] ADDR_MAX     = 19'(MAX_ADDRESS);

  // Per-pixel flags that travel alongside the RAM read.
  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic in_range;
    logic frame_start;
`ifdef FRAME_READER_TEST_PATTERN_EN
    logic       pattern;
    logic [2:0] bar_rgb;
`endif
  } pipe_t;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [18:0] addr_cnt;
  pipe_t       s0;
  pipe_t       pipe_q [RAM_LATENCY];
  pipe_t       tail;
  logic [2:0][COLOR_CHANNEL-1:0] pix_next;

`ifdef FRAME_READER_TEST_PATTERN_EN
  localparam int BAR_W = WIDTH_IMAGE / 8;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;

  // The bar index comes from a compare chain, which avoids a divider on h_cnt.
  always_comb begin
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (h_cnt >= 10'(b * BAR_W)) bar_idx = 3'(b);
    end
  end

  // Bar colours as {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end
`endif

  // Stage 0: flags decoded directly from the raster counters.
  always_comb begin
    s0             = '0;
    s0.active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hsync_n     = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    s0.vsync_n     = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    s0.in_range    = (addr_cnt <= ADDR_MAX);
    s0.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
`ifdef FRAME_READER_TEST_PATTERN_EN
    s0.pattern     = i_pattern_sel;
    s0.bar_rgb     = bar_rgb;
`endif
  end

  // The read strobe is gated by reset. This keeps the strobe low while reset
  // is held, even though the counters then sit on an active pixel.
`ifdef FRAME_READER_TEST_PATTERN_EN
  assign o_rd_enable = i_reset_n && s0.active && s0.in_range && !i_pattern_sel;
`else
  assign o_rd_enable = i_reset_n && s0.active && s0.in_range;
`endif
  assign o_rd_address = addr_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      // The address counter holds through blanking and restarts at 0
      // for the next frame.
      if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) addr_cnt <= '0;
      else if (s0.active)                         addr_cnt <= addr_cnt + 1'b1;
    end
  end

  // The delay pipe matches the RAM latency. Its idle value has the syncs
  // deasserted, so the outputs stay quiet while the pipe refills after reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i]         <= '0;
        pipe_q[i].hsync_n <= 1'b1;
        pipe_q[i].vsync_n <= 1'b1;
      end
    end else begin
      pipe_q[0] <= s0;
      for (int i = 1; i < RAM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[RAM_LATENCY-1];

  always_comb begin
    pix_next = '0;
`ifdef FRAME_READER_TEST_PATTERN_EN
    if (tail.pattern) begin
      if (tail.active) begin
        for (int c = 0; c < 3; c++) pix_next[c] = {COLOR_CHANNEL{tail.bar_rgb[c]}};
      end
    end else if (tail.active && tail.in_range) begin
      pix_next = i_rd_data;
    end
`else
    if (tail.active && tail.in_range) pix_next = i_rd_data;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_data        <= '0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_blank_n     <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_data        <= pix_next;
      o_hsync       <= tail.hsync_n;
      o_vsync       <= tail.vsync_n;
      o_blank_n     <= tail.active;
      o_frame_start <= tail.frame_start;
    end
  end

endmodule
